// File: rtl/fpnew_rob_issuer.sv
`default_nettype none
// ============================================================================
// Module   : fpnew_rob_issuer
// Brief    : Tags and issues core FP requests to the FPU, then retires FPU
//            results to the core in issue order through a reorder buffer.
//            Define FPNEW_ROB_BYPASS_EN for a same-cycle head-result bypass.
// Revision : 1.0 - initial release
// ============================================================================
module fpnew_rob_issuer #(
    parameter int WIDTH     = 64,
    parameter int REQ_WIDTH = 256,
    parameter int DEPTH     = 4,
    localparam int TAG_BITS = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [REQ_WIDTH-1:0] req_data_i,
    output logic                 fpu_valid_o,
    input  logic                 fpu_ready_i,
    output logic [REQ_WIDTH-1:0] fpu_data_o,
    output logic [TAG_BITS-1:0]  fpu_tag_o,
    output logic                 fpu_flush_o,
    input  logic                 fpu_rsp_valid_i,
    output logic                 fpu_rsp_ready_o,
    input  logic [WIDTH-1:0]     fpu_result_i,
    input  logic [4:0]           fpu_status_i,
    input  logic [TAG_BITS-1:0]  fpu_tag_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [WIDTH-1:0]     rsp_result_o,
    output logic [4:0]           rsp_status_o,
    output logic                 busy_o,
    output logic                 tag_err_o
);

    localparam logic [TAG_BITS:0] c_full_count = (TAG_BITS+1)'(DEPTH);

    logic [TAG_BITS-1:0] r_wr_ptr;
    logic [TAG_BITS-1:0] r_rd_ptr;
    logic [TAG_BITS:0]   r_count;
    logic [DEPTH-1:0]    r_alloc;
    logic [DEPTH-1:0]    r_done;
    logic [WIDTH-1:0]    r_result [DEPTH];
    logic [4:0]          r_status [DEPTH];
    logic                r_tag_err;

    logic w_full;
    logic w_issue;
    logic w_rsp_fire;
    logic w_rsp_hit;
    logic w_rsp_bad;
    logic w_head_valid;
    logic w_bypass;
    logic w_write;
    logic w_retire;

    assign w_full      = (r_count == c_full_count);
    assign req_ready_o = fpu_ready_i & ~w_full & ~flush_i;
    assign fpu_valid_o = req_valid_i & ~w_full & ~flush_i;
    assign w_issue     = req_valid_i & req_ready_o;
    assign fpu_data_o  = req_data_i;
    assign fpu_tag_o   = r_wr_ptr;
    assign fpu_flush_o = flush_i;

    // Space is reserved at issue, so only a flush ever stalls the FPU output.
    assign fpu_rsp_ready_o = ~flush_i;
    assign w_rsp_fire      = fpu_rsp_valid_i & ~flush_i;
    assign w_rsp_hit       = w_rsp_fire & r_alloc[fpu_tag_i] & ~r_done[fpu_tag_i];
    assign w_rsp_bad       = w_rsp_fire & ~(r_alloc[fpu_tag_i] & ~r_done[fpu_tag_i]);
    assign w_head_valid    = r_alloc[r_rd_ptr] & r_done[r_rd_ptr];

`ifdef FPNEW_ROB_BYPASS_EN
    assign w_bypass     = w_rsp_hit & (fpu_tag_i == r_rd_ptr);
    assign rsp_valid_o  = w_head_valid | w_bypass;
    assign rsp_result_o = w_bypass ? fpu_result_i : r_result[r_rd_ptr];
    assign rsp_status_o = w_bypass ? fpu_status_i : r_status[r_rd_ptr];
`else
    assign w_bypass     = 1'b0;
    assign rsp_valid_o  = w_head_valid;
    assign rsp_result_o = r_result[r_rd_ptr];
    assign rsp_status_o = r_status[r_rd_ptr];
`endif

    assign w_retire = rsp_valid_o & rsp_ready_i & ~flush_i;
    // A bypassed head that retires immediately never needs its slot written.
    assign w_write  = w_rsp_hit & ~(w_bypass & rsp_ready_i);
    assign busy_o   = (r_count != '0);
    assign tag_err_o = r_tag_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_alloc  <= '0;
            r_done   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_result[i] <= '0;
                r_status[i] <= '0;
            end
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_alloc  <= '0;
            r_done   <= '0;
        end else begin
            // Issue slot is never allocated, so these bit updates cannot collide.
            if (w_issue) begin
                r_alloc[r_wr_ptr] <= 1'b1;
                r_done[r_wr_ptr]  <= 1'b0;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_write) begin
                r_done[fpu_tag_i]   <= 1'b1;
                r_result[fpu_tag_i] <= fpu_result_i;
                r_status[fpu_tag_i] <= fpu_status_i;
            end
            if (w_retire) begin
                r_alloc[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            case ({w_issue, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tag_err <= 1'b0;
        end else if (w_rsp_bad) begin
            r_tag_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire
